// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and the datapath muxes it drives.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [1:0] WRD_RT   = 2'b00;
   localparam logic [1:0] WRD_RD   = 2'b01;
   localparam logic [1:0] WRD_RA   = 2'b10;

   localparam logic [1:0] M2R_ALU  = 2'b00;
   localparam logic [1:0] M2R_MEM  = 2'b01;
   localparam logic [1:0] M2R_LUI  = 2'b10;
   localparam logic [1:0] M2R_PC4  = 2'b11;

   localparam logic [1:0] JMP_SEQ  = 2'b00;
   localparam logic [1:0] JMP_TGT  = 2'b01;
   localparam logic [1:0] JMP_REG  = 2'b10;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   // One-hot instruction class; all-zero means an unsupported instruction (nop).
   typedef struct packed {
      logic addu;
      logic subu;
      logic jr;
      logic ori;
      logic lw;
      logic sw;
      logic beq;
      logic lui;
      logic j;
      logic jal;
   } instr_class_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decode into the one-hot instruction class used by the FSM.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0]   i_opcode,
   input  logic [5:0]   i_funct,
   output instr_class_t o_class
);

   always_comb begin
      o_class = '0;
      case (i_opcode)
         OP_RTYPE: begin
            case (i_funct)
               FN_ADDU: o_class.addu = 1'b1;
               FN_SUBU: o_class.subu = 1'b1;
               FN_JR:   o_class.jr   = 1'b1;
               default: o_class      = '0;
            endcase
         end
         OP_ORI:  o_class.ori = 1'b1;
         OP_LW:   o_class.lw  = 1'b1;
         OP_SW:   o_class.sw  = 1'b1;
         OP_BEQ:  o_class.beq = 1'b1;
         OP_LUI:  o_class.lui = 1'b1;
         OP_J:    o_class.j   = 1'b1;
         OP_JAL:  o_class.jal = 1'b1;
         default: o_class     = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath selects/enables.
module mc_ctrl_fsm (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWr,
   output logic       IRWr,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [1:0] WriteRegDist,
   output logic       ALUSrc,
   output logic [1:0] MemtoReg,
   output logic       Branch,
   output logic [1:0] Jump,
   output logic [2:0] ALUOp,
   output logic [1:0] ExtOp,
   output logic       InstrDone
);
   import mc_ctrl_pkg::*;

   state_t       r_state;
   state_t       w_next;
   instr_class_t w_class;
   logic         w_isExec;
   logic         w_isWb;

   logic       w_pcWr;
   logic       w_irWr;
   logic       w_regWrite;
   logic       w_memWrite;
   logic [1:0] w_writeRegDist;
   logic       w_aluSrc;
   logic [1:0] w_memtoReg;
   logic       w_branch;
   logic [1:0] w_jump;
   logic [2:0] w_aluOp;
   logic [1:0] w_extOp;
   logic       w_instrDone;

   mc_ctrl_decode u_decode (
      .i_opcode (Opcode),
      .i_funct  (Funct),
      .o_class  (w_class)
   );

   assign w_isExec = w_class.addu | w_class.subu | w_class.ori | w_class.lw |
                     w_class.sw | w_class.beq | w_class.lui;
   assign w_isWb   = w_class.addu | w_class.subu | w_class.ori | w_class.lw |
                     w_class.lui | w_class.jal;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next         = ST_FETCH;
      w_pcWr         = 1'b0;
      w_irWr         = 1'b0;
      w_regWrite     = 1'b0;
      w_memWrite     = 1'b0;
      w_writeRegDist = WRD_RT;
      w_aluSrc       = 1'b0;
      w_memtoReg     = M2R_ALU;
      w_branch       = 1'b0;
      w_jump         = JMP_SEQ;
      w_aluOp        = ALU_ADD;
      w_extOp        = EXT_ZERO;
      w_instrDone    = 1'b0;

      case (r_state)
         ST_FETCH: begin
            w_irWr = 1'b1;
            w_pcWr = 1'b1;
            w_next = ST_DECODE;
         end

         // Jumps resolve here; unsupported instructions retire here as a nop.
         ST_DECODE: begin
            if (w_class.j) begin
               w_pcWr      = 1'b1;
               w_jump      = JMP_TGT;
               w_instrDone = 1'b1;
            end else if (w_class.jal) begin
               w_pcWr = 1'b1;
               w_jump = JMP_TGT;
               w_next = ST_WB;
            end else if (w_class.jr) begin
               w_pcWr      = 1'b1;
               w_jump      = JMP_REG;
               w_instrDone = 1'b1;
            end else if (w_isExec) begin
               w_next = ST_EXEC;
            end else begin
               w_instrDone = 1'b1;
            end
         end

         ST_EXEC: begin
            if (w_class.addu) begin
               w_aluOp = ALU_ADD;
               w_next  = ST_WB;
            end else if (w_class.subu) begin
               w_aluOp = ALU_SUB;
               w_next  = ST_WB;
            end else if (w_class.ori) begin
               w_aluSrc = 1'b1;
               w_extOp  = EXT_ZERO;
               w_aluOp  = ALU_OR;
               w_next   = ST_WB;
            end else if (w_class.lw || w_class.sw) begin
               w_aluSrc = 1'b1;
               w_extOp  = EXT_SIGN;
               w_aluOp  = ALU_ADD;
               w_next   = ST_MEM;
            end else if (w_class.lui) begin
               w_extOp = EXT_LUI;
               w_next  = ST_WB;
            end else if (w_class.beq) begin
               w_aluOp     = ALU_SUB;
               w_branch    = 1'b1;
               w_pcWr      = Zero;
               w_instrDone = 1'b1;
            end
         end

         ST_MEM: begin
            if (w_class.sw) begin
               w_memWrite  = 1'b1;
               w_instrDone = 1'b1;
            end else if (w_class.lw) begin
               w_next = ST_WB;
            end
         end

         // The immediate extender feeds the lui writeback path, so keep it in lui mode here.
         ST_WB: begin
            w_instrDone = 1'b1;
            w_regWrite  = w_isWb;
            if (w_class.addu || w_class.subu) begin
               w_writeRegDist = WRD_RD;
               w_memtoReg     = M2R_ALU;
            end else if (w_class.lw) begin
               w_writeRegDist = WRD_RT;
               w_memtoReg     = M2R_MEM;
            end else if (w_class.lui) begin
               w_writeRegDist = WRD_RT;
               w_memtoReg     = M2R_LUI;
               w_extOp        = EXT_LUI;
            end else if (w_class.jal) begin
               w_writeRegDist = WRD_RA;
               w_memtoReg     = M2R_PC4;
            end
         end

         default: begin
            w_next = ST_FETCH;
         end
      endcase
   end

   // Reset must silence everything immediately, even though the state register already reads FETCH.
   assign PCWr         = reset_n & w_pcWr;
   assign IRWr         = reset_n & w_irWr;
   assign RegWrite     = reset_n & w_regWrite;
   assign MemWrite     = reset_n & w_memWrite;
   assign WriteRegDist = reset_n ? w_writeRegDist : WRD_RT;
   assign ALUSrc       = reset_n & w_aluSrc;
   assign MemtoReg     = reset_n ? w_memtoReg : M2R_ALU;
   assign Branch       = reset_n & w_branch;
   assign Jump         = reset_n ? w_jump : JMP_SEQ;
   assign ALUOp        = reset_n ? w_aluOp : ALU_ADD;
   assign ExtOp        = reset_n ? w_extOp : EXT_ZERO;
   assign InstrDone    = reset_n & w_instrDone;

endmodule
